// File: rtl/display_scan_ctrl.sv
// Scan controller that time-multiplexes one 7-segment decoder over N_DIG common-anode digits.
// The displayed value changes only at frame boundaries through a shadow register.
module display_scan_ctrl #(
  parameter int N_DIG = 4,
  parameter int DIV   = 50000,
  parameter int BLANK = 16,
  parameter int LZB   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [4*N_DIG-1:0] din,
  input  logic               neg,
  input  logic               load,
  output logic               pending,
  output logic [N_DIG-1:0]   an,
  output logic [4:0]         digit,
  output logic               sign,
  output logic               frame_tick
);

  localparam int DATA_W = 4 * N_DIG;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W  = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK  = CNT_W'(BLANK);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);
  localparam logic [4:0]       CODE_BLANK = 5'h10;

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  localparam state_t S_RESET = (BLANK > 0) ? S_BLANK : S_DRIVE;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [DATA_W-1:0]  disp, shadow;
  logic               disp_neg, shadow_neg;
  logic               boundary;
  logic               lz_blank;
  logic [N_DIG-1:0]   an_nxt;
  logic [4:0]         digit_nxt;
  logic               sign_nxt;

  function automatic logic [3:0] nibble(input logic [DATA_W-1:0] v, input logic [IDX_W-1:0] i);
    logic [DATA_W-1:0] sh;
    sh = v >> {i, 2'b00};
    return sh[3:0];
  endfunction

  // True when nibble i and every more-significant nibble are zero.
  function automatic logic upper_zero(input logic [DATA_W-1:0] v, input logic [IDX_W-1:0] i);
    logic [DATA_W-1:0] sh;
    sh = v >> {i, 2'b00};
    return (sh == '0);
  endfunction

  // Slot/digit counters
  always_comb begin
    boundary = (idx == IDX_LAST) && (cnt == CNT_LAST);
    cnt_nxt  = cnt + CNT_W'(1);
    idx_nxt  = idx;
    if (cnt == CNT_LAST) begin
      cnt_nxt = '0;
      idx_nxt = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      state <= S_RESET;
    end else begin
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      state <= state_nxt;
    end
  end

  // Next state follows the counter; outputs are decoded from the current slot position.
  always_comb begin
    state_nxt = ((BLANK > 0) && (cnt_nxt < CNT_BLANK)) ? S_BLANK : S_DRIVE;
    an_nxt    = '1;
    digit_nxt = CODE_BLANK;
    sign_nxt  = 1'b0;
    lz_blank  = (LZB != 0) && (idx != '0) && upper_zero(disp, idx);
    if (state == S_DRIVE && !lz_blank) begin
      an_nxt[idx] = 1'b0;
      digit_nxt   = {1'b0, nibble(disp, idx)};
      sign_nxt    = (idx == IDX_LAST) && disp_neg;
    end
  end

  // Output register stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an         <= '1;
      digit      <= CODE_BLANK;
      sign       <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      an         <= an_nxt;
      digit      <= digit_nxt;
      sign       <= sign_nxt;
      frame_tick <= boundary;
    end
  end

  // A load coinciding with the boundary bypasses the shadow so it is shown in the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp       <= '0;
      disp_neg   <= 1'b0;
      shadow     <= '0;
      shadow_neg <= 1'b0;
      pending    <= 1'b0;
    end else if (boundary && load) begin
      disp       <= din;
      disp_neg   <= neg;
      shadow     <= din;
      shadow_neg <= neg;
      pending    <= 1'b0;
    end else if (boundary && pending) begin
      disp     <= shadow;
      disp_neg <= shadow_neg;
      pending  <= 1'b0;
    end else if (load) begin
      shadow     <= din;
      shadow_neg <= neg;
      pending    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: frame-position reference model checked every cycle on two
// instances (leading-zero blanking on and off), plus literal frame checks.
module tb_display_scan_ctrl;

  localparam int N_DIG = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int W     = 4 * N_DIG;
  localparam int FRAME = N_DIG * DIV;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         neg = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] din = '0;

  logic             pending1, pending0, tick1, tick0, sign1, sign0;
  logic [N_DIG-1:0] an1, an0;
  logic [4:0]       dig1, dig0;

  display_scan_ctrl #(.N_DIG(N_DIG), .DIV(DIV), .BLANK(BLANK), .LZB(1)) dut (
    .clk(clk), .rst(rst), .din(din), .neg(neg), .load(load), .pending(pending1),
    .an(an1), .digit(dig1), .sign(sign1), .frame_tick(tick1));

  display_scan_ctrl #(.N_DIG(N_DIG), .DIV(DIV), .BLANK(BLANK), .LZB(0)) dut_nolzb (
    .clk(clk), .rst(rst), .din(din), .neg(neg), .load(load), .pending(pending0),
    .an(an0), .digit(dig0), .sign(sign0), .frame_tick(tick0));

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: the scan position within the frame, the shown value and the shadow.
  int           m_p = 0;
  logic [W-1:0] m_disp = '0, m_sh = '0;
  logic         m_neg = 1'b0, m_shn = 1'b0, m_pend = 1'b0;
  logic [N_DIG-1:0] e_an1 = '1, e_an0 = '1;
  logic [4:0]   e_dg1 = 5'h10, e_dg0 = 5'h10;
  logic         e_sg1 = 1'b0, e_sg0 = 1'b0, e_tick = 1'b0;

  function automatic logic [9:0] model_out(input int pos, input bit lzb,
                                           input logic [W-1:0] d, input logic n);
    int i = pos / DIV;
    int c = pos % DIV;
    logic [N_DIG-1:0] a = '1;
    logic [4:0] g = 5'h10;
    logic s = 1'b0;
    logic [W-1:0] upper = d >> (4 * i);
    if (c >= BLANK && !(lzb && i > 0 && upper == '0)) begin
      a[i] = 1'b0;
      g = {1'b0, upper[3:0]};
      s = (i == N_DIG - 1) ? n : 1'b0;
    end
    return {a, g, s};
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_p <= 0; m_disp <= '0; m_neg <= 1'b0; m_sh <= '0; m_shn <= 1'b0; m_pend <= 1'b0;
      {e_an1, e_dg1, e_sg1} <= {{N_DIG{1'b1}}, 5'h10, 1'b0};
      {e_an0, e_dg0, e_sg0} <= {{N_DIG{1'b1}}, 5'h10, 1'b0};
      e_tick <= 1'b0;
    end else begin
      {e_an1, e_dg1, e_sg1} <= model_out(m_p, 1'b1, m_disp, m_neg);
      {e_an0, e_dg0, e_sg0} <= model_out(m_p, 1'b0, m_disp, m_neg);
      e_tick <= (m_p == FRAME - 1);
      if (m_p == FRAME - 1 && load) begin
        m_disp <= din; m_neg <= neg; m_sh <= din; m_shn <= neg; m_pend <= 1'b0;
      end else if (m_p == FRAME - 1 && m_pend) begin
        m_disp <= m_sh; m_neg <= m_shn; m_pend <= 1'b0;
      end else if (load) begin
        m_sh <= din; m_shn <= neg; m_pend <= 1'b1;
      end
      m_p <= (m_p + 1) % FRAME;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("an", 32'(an1), 32'(e_an1));
      chk("digit", 32'(dig1), 32'(e_dg1));
      chk("sign", 32'(sign1), 32'(e_sg1));
      chk("frame_tick", 32'(tick1), 32'(e_tick));
      chk("pending", 32'(pending1), 32'(m_pend));
      chk("an_nolzb", 32'(an0), 32'(e_an0));
      chk("digit_nolzb", 32'(dig0), 32'(e_dg0));
      chk("sign_nolzb", 32'(sign0), 32'(e_sg0));
      chk("frame_tick_nolzb", 32'(tick0), 32'(e_tick));
      chk("pending_nolzb", 32'(pending0), 32'(m_pend));
    end
  end

  task automatic wait_pos(input int p);
    for (int k = 0; k < 4 * FRAME; k++) begin
      @(negedge clk);
      if (m_p == p) return;
    end
    timeout("wait_pos");
  endtask

  task automatic do_load(input logic [W-1:0] v, input logic n);
    din = v; neg = n; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_tick();
    for (int k = 0; k < 4 * FRAME; k++) begin
      if (tick1 === 1'b1) return;
      @(negedge clk);
    end
    timeout("wait_tick");
  endtask

  // Called at the negedge where frame_tick is high; checks the whole following frame.
  task automatic check_frame(input logic [15:0] a1, input logic [19:0] g1, input logic [3:0] s1,
                             input logic [15:0] a0, input logic [19:0] g0, input logic [3:0] s0);
    for (int k = 0; k < FRAME; k++) begin
      int s = k / DIV;
      bit bl = (k % DIV) < BLANK;
      @(negedge clk);
      chk("lit_an", 32'(an1), bl ? 32'hF : 32'(a1[4*s +: 4]));
      chk("lit_digit", 32'(dig1), bl ? 32'h10 : 32'(g1[5*s +: 5]));
      chk("lit_sign", 32'(sign1), bl ? 32'h0 : 32'(s1[s]));
      chk("lit_an_nolzb", 32'(an0), bl ? 32'hF : 32'(a0[4*s +: 4]));
      chk("lit_digit_nolzb", 32'(dig0), bl ? 32'h10 : 32'(g0[5*s +: 5]));
      chk("lit_sign_nolzb", 32'(sign0), bl ? 32'h0 : 32'(s0[s]));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an1), 32'hF);
    chk("rst_digit", 32'(dig1), 32'h10);
    chk("rst_sign", 32'(sign1), 32'h0);
    chk("rst_pending", 32'(pending1), 32'h0);
    chk("rst_tick", 32'(tick1), 32'h0);
    rst = 1'b0;

    do_load(16'h12A0, 1'b1);
    wait_tick();
    check_frame(16'h7BDE, {5'h01, 5'h02, 5'h0A, 5'h00}, 4'b1000,
                16'h7BDE, {5'h01, 5'h02, 5'h0A, 5'h00}, 4'b1000);

    wait_pos(10);
    do_load(16'h1111, 1'b0);
    chk("mid_pending", 32'(pending1), 32'h1);
    wait_pos(14);
    chk("old_an", 32'(an1), 32'hD);
    chk("old_digit", 32'(dig1), 32'h0A);
    wait_tick();
    chk("bound_pending", 32'(pending1), 32'h0);
    check_frame(16'h7BDE, {5'h01, 5'h01, 5'h01, 5'h01}, 4'b0000,
                16'h7BDE, {5'h01, 5'h01, 5'h01, 5'h01}, 4'b0000);

    do_load(16'h0005, 1'b1);
    wait_tick();
    check_frame(16'hFFFE, {5'h10, 5'h10, 5'h10, 5'h05}, 4'b0000,
                16'h7BDE, {5'h00, 5'h00, 5'h00, 5'h05}, 4'b1000);
    do_load(16'h0000, 1'b0);
    wait_tick();
    check_frame(16'hFFFE, {5'h10, 5'h10, 5'h10, 5'h00}, 4'b0000,
                16'h7BDE, {5'h00, 5'h00, 5'h00, 5'h00}, 4'b0000);

    wait_pos(2);
    do_load(16'h2222, 1'b0);
    do_load(16'h3333, 1'b0);
    wait_tick();
    check_frame(16'h7BDE, {5'h03, 5'h03, 5'h03, 5'h03}, 4'b0000,
                16'h7BDE, {5'h03, 5'h03, 5'h03, 5'h03}, 4'b0000);

    wait_pos(FRAME - 1);
    do_load(16'h4444, 1'b0);
    chk("bypass_pending", 32'(pending1), 32'h0);
    chk("bypass_tick", 32'(tick1), 32'h1);
    check_frame(16'h7BDE, {5'h04, 5'h04, 5'h04, 5'h04}, 4'b0000,
                16'h7BDE, {5'h04, 5'h04, 5'h04, 5'h04}, 4'b0000);

    wait_pos(12);
    do_load(16'h5678, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_an", 32'(an1), 32'hF);
    chk("arst_digit", 32'(dig1), 32'h10);
    chk("arst_sign", 32'(sign1), 32'h0);
    chk("arst_pending", 32'(pending1), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("post_rst_an", 32'(an1), (k < 3) ? 32'hF : 32'hE);
      chk("post_rst_digit", 32'(dig1), (k < 3) ? 32'h10 : 32'h00);
    end

    for (int k = 0; k < 2500; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 11) == 0) begin
        din  = 16'($urandom) >> (4 * $urandom_range(0, 4));
        neg  = 1'($urandom_range(0, 1));
        load = 1'b1;
      end else begin
        load = 1'b0;
      end
    end
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
